// File: rtl/tlul_host_arb_pkg.sv
// ---------------------------------------------------------------------------
// tlul_host_arb_pkg: TL-UL channel structs, arbiter state codes, host index.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package tlul_host_arb_pkg;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t StIdle  = 2'd0;
  localparam arb_state_t StOwn0  = 2'd1;
  localparam arb_state_t StOwn1  = 2'd2;
  localparam arb_state_t StDrain = 2'd3;

  typedef logic host_idx_t;

endpackage

`default_nettype wire

// File: rtl/tlul_host_arb_cnt.sv
// ---------------------------------------------------------------------------
// tlul_host_arb_cnt: saturating up/down counter; simultaneous inc/dec holds.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tlul_host_arb_cnt #(
  parameter int Max = 4,
  parameter int W   = $clog2(Max + 1)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] cnt_d_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && (cnt_q != W'(Max))) begin
      cnt_d = cnt_q + W'(1);
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign cnt_d_o = cnt_d;

endmodule

`default_nettype wire

// File: rtl/tlul_host_arb.sv
// ---------------------------------------------------------------------------
// tlul_host_arb: two-host TL-UL arbiter, hand-off only after responses drain.
// Optional macro TLUL_HOST_ARB_PERF_EN adds grant/stall counters. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tlul_host_arb
  import tlul_host_arb_pkg::*;
#(
  parameter int MaxOutstanding = 4,
  parameter int MaxBurst       = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  tl_h2d_t     tl_h0_i,
  output tl_d2h_t     tl_h0_o,
  input  tl_h2d_t     tl_h1_i,
  output tl_d2h_t     tl_h1_o,
  output tl_h2d_t     tl_dev_o,
  input  tl_d2h_t     tl_dev_i,
  output logic        spurious_rsp_o
`ifdef TLUL_HOST_ARB_PERF_EN
  ,
  output logic [31:0] perf_grant0_o,
  output logic [31:0] perf_grant1_o,
  output logic [31:0] perf_stall_o
`endif
);

  localparam int OutW   = $clog2(MaxOutstanding + 1);
  localparam int BurstW = $clog2(MaxBurst + 1);

  arb_state_t        state_q, state_d;
  host_idx_t         owner_q, owner_d;
  host_idx_t         prio_q, prio_d;
  logic [BurstW-1:0] burst_cnt_q, burst_cnt_d;
  logic [OutW-1:0]   out_cnt_q, out_cnt_d;

  tl_h2d_t own_req;
  tl_d2h_t rsp;
  logic    granted, routed, cap, a_open, spurious, a_hs, d_hs;

  always_comb begin
    own_req  = owner_q ? tl_h1_i : tl_h0_i;
    granted  = (state_q == StOwn0) || (state_q == StOwn1);
    routed   = granted || (state_q == StDrain);
    // Caps come from registered counts so a_ready never collapses mid-cycle.
    cap      = (out_cnt_q == OutW'(MaxOutstanding)) || (burst_cnt_q == BurstW'(MaxBurst));
    a_open   = granted && !cap;
    spurious = tl_dev_i.d_valid && (out_cnt_q == '0);

    tl_dev_o         = own_req;
    tl_dev_o.a_valid = own_req.a_valid && a_open;
    tl_dev_o.d_ready = (routed && !spurious) ? own_req.d_ready : 1'b1;

    rsp         = tl_dev_i;
    rsp.d_valid = tl_dev_i.d_valid && !spurious;
    rsp.a_ready = tl_dev_i.a_ready && a_open;

    tl_h0_o = (routed && !owner_q) ? rsp : '0;
    tl_h1_o = (routed &&  owner_q) ? rsp : '0;

    a_hs = tl_dev_o.a_valid && tl_dev_i.a_ready;
    d_hs = tl_dev_i.d_valid && tl_dev_o.d_ready && !spurious;
  end

  assign spurious_rsp_o = spurious;

  tlul_host_arb_cnt #(
    .Max (MaxOutstanding),
    .W   (OutW)
  ) u_out_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (a_hs),
    .dec_i   (d_hs),
    .cnt_o   (out_cnt_q),
    .cnt_d_o (out_cnt_d)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    prio_d      = prio_q;
    burst_cnt_d = a_hs ? burst_cnt_q + BurstW'(1) : burst_cnt_q;
    case (state_q)
      StIdle: begin
        if (tl_h0_i.a_valid || tl_h1_i.a_valid) begin
          owner_d     = (tl_h0_i.a_valid && tl_h1_i.a_valid) ? prio_q : tl_h1_i.a_valid;
          state_d     = owner_d ? StOwn1 : StOwn0;
          burst_cnt_d = '0;
        end
      end
      StOwn0, StOwn1: begin
        if (burst_cnt_d == BurstW'(MaxBurst)) begin
          state_d = StDrain;
        end else if (!own_req.a_valid && (out_cnt_d == '0)) begin
          state_d = StIdle;
          prio_d  = ~owner_q;
        end
      end
      StDrain: begin
        if (out_cnt_d == '0) begin
          state_d = StIdle;
          prio_d  = ~owner_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      owner_q     <= 1'b0;
      prio_q      <= 1'b0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      prio_q      <= prio_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

`ifdef TLUL_HOST_ARB_PERF_EN
  logic [31:0] perf_grant0_q, perf_grant1_q, perf_stall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_grant0_q <= '0;
      perf_grant1_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (a_hs && !owner_q) perf_grant0_q <= perf_grant0_q + 32'd1;
      if (a_hs &&  owner_q) perf_grant1_q <= perf_grant1_q + 32'd1;
      if (routed && (owner_q ? tl_h0_i.a_valid : tl_h1_i.a_valid)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_grant0_o = perf_grant0_q;
  assign perf_grant1_o = perf_grant1_q;
  assign perf_stall_o  = perf_stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tlul_host_arb.sv
// ---------------------------------------------------------------------------
// tb_tlul_host_arb: directed scoreboard bench for tlul_host_arb. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_tlul_host_arb;
  import tlul_host_arb_pkg::*;

  typedef struct {
    logic [7:0]  src;
    logic [31:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    logic [7:0]  src;
    logic [31:0] data;
  } exp_t;

  localparam logic [7:0] Src0 = 8'h10;
  localparam logic [7:0] Src1 = 8'h20;

  logic    clk = 1'b0;
  logic    rst;
  tl_h2d_t tl_h0_i, tl_h1_i, tl_dev_o;
  tl_d2h_t tl_h0_o, tl_h1_o, tl_dev_i;
  logic    spurious_rsp_o;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0] hq0[$];
  logic [31:0] hq1[$];
  exp_t        exp0[$];
  exp_t        exp1[$];
  pend_t       pend[$];

  logic dev_en, dev_ardy, spur_inj, a_hs, d_hs, saw_drain;
  int   acc0, acc1, rsp0, rsp1, dev_acc, last_rsp0, gap01, acc0_at_h1;

  tlul_host_arb #(
    .MaxOutstanding (4),
    .MaxBurst       (8)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .tl_h0_i        (tl_h0_i),
    .tl_h0_o        (tl_h0_o),
    .tl_h1_i        (tl_h1_i),
    .tl_h1_o        (tl_h1_o),
    .tl_dev_o       (tl_dev_o),
    .tl_dev_i       (tl_dev_i),
    .spurious_rsp_o (spurious_rsp_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rsp_data(input logic [7:0] src, input logic [31:0] addr);
    return addr ^ 32'h5A5A_0000 ^ {24'h0, src};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mon_rsp(input int h, input tl_d2h_t r);
    exp_t e;
    if (h == 0) begin
      rsp0++;
      last_rsp0 = cyc;
      chk("h0_rsp_expected", 32'(exp0.size() > 0), 32'd1);
      if (exp0.size() > 0) begin
        e = exp0.pop_front();
        chk("h0_rsp_data", r.d_data, e.data);
        chk("h0_rsp_src", 32'(r.d_source), 32'(e.src));
      end
    end else begin
      rsp1++;
      chk("h1_rsp_expected", 32'(exp1.size() > 0), 32'd1);
      if (exp1.size() > 0) begin
        e = exp1.pop_front();
        chk("h1_rsp_data", r.d_data, e.data);
        chk("h1_rsp_src", 32'(r.d_source), 32'(e.src));
      end
    end
  endtask

  // One clock: drive at negedge, sample 1ns later, update models.
  task automatic step();
    @(negedge clk);
    cyc++;
    tl_h0_i.a_valid = (hq0.size() > 0);
    if (hq0.size() > 0) tl_h0_i.a_address = hq0[0];
    tl_h1_i.a_valid = (hq1.size() > 0);
    if (hq1.size() > 0) tl_h1_i.a_address = hq1[0];
    tl_dev_i = '0;
    tl_dev_i.a_ready = dev_ardy;
    if (spur_inj) begin
      tl_dev_i.d_valid  = 1'b1;
      tl_dev_i.d_data   = 32'hDEAD_BEEF;
      tl_dev_i.d_source = Src0;
    end else if (dev_en && (pend.size() > 0) && (pend[0].due <= cyc)) begin
      tl_dev_i.d_valid  = 1'b1;
      tl_dev_i.d_opcode = 3'd1;
      tl_dev_i.d_size   = 2'd2;
      tl_dev_i.d_source = pend[0].src;
      tl_dev_i.d_data   = rsp_data(pend[0].src, pend[0].addr);
    end
    #1;
    if (dut.state_q == StDrain) saw_drain = 1'b1;
    if (tl_h0_o.d_valid === 1'b1) mon_rsp(0, tl_h0_o);
    if (tl_h1_o.d_valid === 1'b1) mon_rsp(1, tl_h1_o);
    a_hs = tl_dev_o.a_valid && tl_dev_i.a_ready;
    d_hs = tl_dev_i.d_valid && tl_dev_o.d_ready;
    if ((tl_h0_i.a_valid && tl_h0_o.a_ready) === 1'b1) begin
      exp0.push_back('{Src0, rsp_data(Src0, hq0[0])});
      void'(hq0.pop_front());
      acc0++;
    end
    if ((tl_h1_i.a_valid && tl_h1_o.a_ready) === 1'b1) begin
      exp1.push_back('{Src1, rsp_data(Src1, hq1[0])});
      void'(hq1.pop_front());
      acc1++;
      gap01      = cyc - last_rsp0;
      acc0_at_h1 = acc0;
    end
    if (a_hs === 1'b1) begin
      pend.push_back('{tl_dev_o.a_source, tl_dev_o.a_address, cyc + 2});
      dev_acc++;
    end
    if ((d_hs === 1'b1) && !spur_inj && (pend.size() > 0)) void'(pend.pop_front());
  endtask

  task automatic do_reset();
    hq0.delete(); hq1.delete(); exp0.delete(); exp1.delete(); pend.delete();
    acc0 = 0; acc1 = 0; rsp0 = 0; rsp1 = 0; dev_acc = 0;
    last_rsp0 = 0; gap01 = -1; acc0_at_h1 = -1; saw_drain = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    tl_h0_i = '0; tl_h1_i = '0; tl_dev_i = '0;
    tl_h0_i.a_opcode = 3'd4; tl_h0_i.a_size = 2'd2; tl_h0_i.a_mask = 4'hF;
    tl_h0_i.a_source = Src0; tl_h0_i.d_ready = 1'b1;
    tl_h1_i.a_opcode = 3'd4; tl_h1_i.a_size = 2'd2; tl_h1_i.a_mask = 4'hF;
    tl_h1_i.a_source = Src1; tl_h1_i.d_ready = 1'b1;
    dev_en = 1'b1; dev_ardy = 1'b1; spur_inj = 1'b0;

    // Reset values
    do_reset();
    chk("rst_dev_a_valid", 32'(tl_dev_o.a_valid), 32'd0);
    chk("rst_dev_d_ready", 32'(tl_dev_o.d_ready), 32'd1);
    chk("rst_h0_a_ready", 32'(tl_h0_o.a_ready), 32'd0);
    chk("rst_h1_a_ready", 32'(tl_h1_o.a_ready), 32'd0);
    chk("rst_h0_d_valid", 32'(tl_h0_o.d_valid), 32'd0);
    chk("rst_spurious", 32'(spurious_rsp_o), 32'd0);

    // Single host, 3 Gets, 2-cycle device latency; A+D overlap at out_cnt=2
    hq0.push_back(32'h0000_1000); hq0.push_back(32'h0000_1004); hq0.push_back(32'h0000_1008);
    step();
    chk("idle_no_grant", 32'(tl_h0_o.a_ready), 32'd0);
    step();
    step();
    step();
    chk("sim_hs_a", 32'(a_hs), 32'd1);
    chk("sim_hs_d", 32'(d_hs), 32'd1);
    chk("sim_hs_cnt_before", 32'(dut.out_cnt_q), 32'd2);
    step();
    chk("sim_hs_cnt_after", 32'(dut.out_cnt_q), 32'd2);
    repeat (5) step();
    chk("single_rsp0", 32'(rsp0), 32'd3);
    chk("single_rsp1", 32'(rsp1), 32'd0);
    chk("single_state", 32'(dut.state_q), 32'(StIdle));
    chk("single_prio", 32'(dut.prio_q), 32'd1);
    chk("single_out_cnt", 32'(dut.out_cnt_q), 32'd0);

    // Contention out of reset: host 0 first, then host 1 intact
    do_reset();
    hq0.push_back(32'h0000_2000); hq0.push_back(32'h0000_2004);
    hq1.push_back(32'h0000_3000); hq1.push_back(32'h0000_3004);
    step();
    step();
    chk("cont_h0_granted", 32'(tl_h0_o.a_ready), 32'd1);
    chk("cont_h1_blocked", 32'(tl_h1_o.a_ready), 32'd0);
    repeat (20) step();
    chk("cont_rsp0", 32'(rsp0), 32'd2);
    chk("cont_rsp1", 32'(rsp1), 32'd2);
    chk("cont_state", 32'(dut.state_q), 32'(StIdle));
    chk("cont_prio", 32'(dut.prio_q), 32'd0);

    // Outstanding cap with device responses held off
    do_reset();
    dev_en = 1'b0;
    for (int i = 0; i < 6; i++) hq0.push_back(32'h0000_4000 + 32'(i * 4));
    repeat (8) step();
    chk("cap_dev_acc", 32'(dev_acc), 32'd4);
    chk("cap_a_ready_low", 32'(tl_h0_o.a_ready), 32'd0);
    chk("cap_out_cnt", 32'(dut.out_cnt_q), 32'd4);
    dev_en = 1'b1;
    step();
    chk("cap_first_rsp_a_ready", 32'(tl_h0_o.a_ready), 32'd0);
    repeat (20) step();
    chk("cap_rsp0", 32'(rsp0), 32'd6);
    chk("cap_dev_acc_total", 32'(dev_acc), 32'd6);

    // Burst cap forces hand-off to the pending host
    do_reset();
    for (int i = 0; i < 12; i++) hq0.push_back(32'h0000_5000 + 32'(i * 4));
    hq1.push_back(32'h0000_6000);
    repeat (50) step();
    chk("burst_saw_drain", 32'(saw_drain), 32'd1);
    chk("burst_acc0_at_h1", 32'(acc0_at_h1), 32'd8);
    chk("burst_turnaround", 32'(gap01), 32'd2);
    chk("burst_rsp0", 32'(rsp0), 32'd12);
    chk("burst_rsp1", 32'(rsp1), 32'd1);

    // Spurious response while idle
    spur_inj = 1'b1;
    step();
    chk("spur_pulse", 32'(spurious_rsp_o), 32'd1);
    chk("spur_d_ready", 32'(tl_dev_o.d_ready), 32'd1);
    chk("spur_h0_d_valid", 32'(tl_h0_o.d_valid), 32'd0);
    chk("spur_h1_d_valid", 32'(tl_h1_o.d_valid), 32'd0);
    spur_inj = 1'b0;
    step();
    chk("spur_one_cycle", 32'(spurious_rsp_o), 32'd0);
    chk("spur_out_cnt", 32'(dut.out_cnt_q), 32'd0);

    // Reset with 3 requests in flight
    do_reset();
    dev_en = 1'b0;
    hq0.push_back(32'h0000_7000); hq0.push_back(32'h0000_7004); hq0.push_back(32'h0000_7008);
    repeat (5) step();
    chk("midrst_out_cnt_pre", 32'(dut.out_cnt_q), 32'd3);
    hq0.delete(); exp0.delete();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("midrst_out_cnt", 32'(dut.out_cnt_q), 32'd0);
    chk("midrst_state", 32'(dut.state_q), 32'(StIdle));
    chk("midrst_dev_a_valid", 32'(tl_dev_o.a_valid), 32'd0);
    chk("midrst_dev_d_ready", 32'(tl_dev_o.d_ready), 32'd1);
    chk("midrst_h0_a_ready", 32'(tl_h0_o.a_ready), 32'd0);
    chk("midrst_spurious", 32'(spurious_rsp_o), 32'd0);
    dev_en = 1'b1;
    step();
    chk("midrst_late_rsp_spur", 32'(spurious_rsp_o), 32'd1);
    chk("midrst_late_rsp_h0", 32'(tl_h0_o.d_valid), 32'd0);
    repeat (4) step();
    chk("midrst_flushed", 32'(pend.size()), 32'd0);
    chk("midrst_out_cnt_end", 32'(dut.out_cnt_q), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
